// File: rtl/palette_pkg.sv
// Shared state encoding and sizing helper for the palette bank loader.
package palette_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PEND = 2'd2
   } pal_state_t;

   function automatic int pal_bytes(input int entries, input int bpe);
      return entries * bpe;
   endfunction

endpackage

// File: rtl/palette_shadow.sv
// Shadow palette buffer: MSB-first byte placement, saturating byte count, short/overflow status.
// Latency: byte visible in shadow_o the cycle after wr_i; no backpressure, writes past the end only flag overflow.
module palette_shadow
   import palette_pkg::*;
#(
   parameter int ENTRIES = 4,
   parameter int BPE     = 4
) (
   input  logic                       clk_sys,
   input  logic                       reset,
   input  logic                       start_i,
   input  logic                       wr_i,
   input  logic [7:0]                 data_i,
   output logic [ENTRIES*BPE*8-1:0]   shadow_o,
   output logic                       complete_o,
   output logic                       short_o,
   output logic                       overflow_o
);

   localparam int NB = pal_bytes(ENTRIES, BPE);
   localparam int CW = $clog2(NB + 1);

   logic [CW-1:0]   count_q, count_d;
   logic [NB*8-1:0] shadow_q, shadow_d;
   logic            ovf_q, ovf_d;

   always_comb begin
      count_d  = count_q;
      shadow_d = shadow_q;
      ovf_d    = ovf_q;
      if (start_i) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (wr_i) begin
         if (count_q < CW'(NB)) begin
            // byte 0 lands in the most significant byte lane
            for (int i = 0; i < NB; i++) begin
               if (count_q == CW'(i)) begin
                  shadow_d[(NB-1-i)*8 +: 8] = data_i;
               end
            end
            count_d = count_q + CW'(1);
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         count_q  <= '0;
         shadow_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         count_q  <= count_d;
         shadow_q <= shadow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign shadow_o   = shadow_q;
   assign complete_o = (count_q == CW'(NB)) && !ovf_q;
   assign short_o    = (count_q < CW'(NB));
   assign overflow_o = ovf_q;

endmodule

// File: rtl/palette_bank_loader.sv
// Loads palettes from the ioctl stream into a shadow and commits them to one of BANKS banks on vblank rise.
// Latency: rd_rgb is registered (1 cycle); no backpressure, the ioctl stream is never stalled.
module palette_bank_loader
   import palette_pkg::*;
#(
   parameter int                          ENTRIES = 4,
   parameter int                          BPE     = 4,
   parameter int                          BANKS   = 2,
   parameter logic [7:0]                  IDX     = 8'd3,
   parameter logic [ENTRIES*BPE*8-1:0]    DEF_PAL = 128'h00000032cd320000ff00ffff00000000,
   parameter int                          BW      = (BANKS > 1) ? $clog2(BANKS) : 1,
   parameter int                          IW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
   input  logic            clk_sys,
   input  logic            reset,
   input  logic            ioctl_download,
   input  logic [7:0]      ioctl_index,
   input  logic            ioctl_wr,
   input  logic [7:0]      ioctl_data,
   input  logic [BW-1:0]   load_bank,
   input  logic            vblank,
   input  logic [BW-1:0]   rd_bank,
   input  logic [IW-1:0]   rd_index,
   output logic [23:0]     rd_rgb,
   output logic            busy,
   output logic            pending,
   output logic            err_short,
   output logic            err_long,
   output logic            commit_pulse
);

   localparam int NB = pal_bytes(ENTRIES, BPE);
   localparam int PW = NB * 8;
   localparam int EW = BPE * 8;

   pal_state_t    state_q, state_d;
   logic          sel, sel_q, sel_rise, sel_fall;
   logic          vblank_q, vb_rise;
   logic [BW-1:0] tgt_q, tgt_d;
   logic          err_short_q, err_short_d;
   logic          err_long_q, err_long_d;
   logic          commit, commit_q;
   logic [23:0]   rd_rgb_q, rd_rgb_d;
   logic [PW-1:0] bank_q [BANKS];
   logic [PW-1:0] shadow;
   logic          sh_wr, sh_complete, sh_short, sh_ovf;

   assign sel      = ioctl_download && (ioctl_index == IDX);
   assign sel_rise = sel && !sel_q;
   assign sel_fall = !sel && sel_q;
   assign vb_rise  = vblank && !vblank_q;
   assign sh_wr    = (state_q == LOAD) && sel && ioctl_wr;

   palette_shadow #(
      .ENTRIES (ENTRIES),
      .BPE     (BPE)
   ) u_shadow (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .start_i    (sel_rise),
      .wr_i       (sh_wr),
      .data_i     (ioctl_data),
      .shadow_o   (shadow),
      .complete_o (sh_complete),
      .short_o    (sh_short),
      .overflow_o (sh_ovf)
   );

   // A new download always wins over a pending commit, even on the same cycle.
   always_comb begin
      state_d     = state_q;
      tgt_d       = tgt_q;
      err_short_d = err_short_q;
      err_long_d  = err_long_q;
      commit      = 1'b0;
      if (sel_rise) begin
         state_d     = LOAD;
         tgt_d       = load_bank;
         err_short_d = 1'b0;
         err_long_d  = 1'b0;
      end else begin
         unique case (state_q)
            LOAD: begin
               if (sel_fall) begin
                  state_d     = sh_complete ? PEND : IDLE;
                  err_short_d = sh_short;
                  err_long_d  = sh_ovf;
               end
            end
            PEND: begin
               if (vb_rise) begin
                  state_d = IDLE;
                  commit  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         sel_q       <= 1'b0;
         vblank_q    <= 1'b0;
         tgt_q       <= '0;
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;
         commit_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel;
         vblank_q    <= vblank;
         tgt_q       <= tgt_d;
         err_short_q <= err_short_d;
         err_long_q  <= err_long_d;
         commit_q    <= commit;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < BANKS; b++) begin
            bank_q[b] <= DEF_PAL;
         end
      end else if (commit) begin
         for (int b = 0; b < BANKS; b++) begin
            if (tgt_q == BW'(b)) begin
               bank_q[b] <= shadow;
            end
         end
      end
   end

   // Out-of-range banks match nothing and read back as zero.
   always_comb begin
      rd_rgb_d = '0;
      for (int b = 0; b < BANKS; b++) begin
         for (int e = 0; e < ENTRIES; e++) begin
            if (rd_bank == BW'(b) && rd_index == IW'(e)) begin
               rd_rgb_d = bank_q[b][(ENTRIES-1-e)*EW +: 24];
            end
         end
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         rd_rgb_q <= '0;
      end else begin
         rd_rgb_q <= rd_rgb_d;
      end
   end

   assign rd_rgb       = rd_rgb_q;
   assign busy         = (state_q == LOAD);
   assign pending      = (state_q == PEND);
   assign err_short    = err_short_q;
   assign err_long     = err_long_q;
   assign commit_pulse = commit_q;

endmodule

// File: tb/tb_palette_bank_loader.sv
// Directed bench for palette_bank_loader: reset contents, commits, short/long downloads, vblank and reset corner cases.
module tb_palette_bank_loader;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [7:0]  ioctl_data;
   logic [0:0]  load_bank;
   logic        vblank;
   logic [0:0]  rd_bank;
   logic [1:0]  rd_index;
   logic [23:0] rd_rgb;
   logic        busy, pending, err_short, err_long, commit_pulse;

   int errors = 0;
   int checks = 0;

   palette_bank_loader dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_data     (ioctl_data),
      .load_bank      (load_bank),
      .vblank         (vblank),
      .rd_bank        (rd_bank),
      .rd_index       (rd_index),
      .rd_rgb         (rd_rgb),
      .busy           (busy),
      .pending        (pending),
      .err_short      (err_short),
      .err_long       (err_long),
      .commit_pulse   (commit_pulse)
   );

   always #5 clk_sys = ~clk_sys;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic start_dl(input int bank, input int idx);
      load_bank      = 1'(bank);
      ioctl_index    = 8'(idx);
      ioctl_download = 1'b1;
      tick();
   endtask

   task automatic send_bytes(input int n, input int base, input int step);
      for (int i = 0; i < n; i++) begin
         ioctl_data = 8'(base + i * step);
         ioctl_wr   = 1'b1;
         tick();
         ioctl_wr   = 1'b0;
         tick();
      end
   endtask

   task automatic end_dl();
      ioctl_download = 1'b0;
      tick();
   endtask

   task automatic read(input string tag, input int bank, input int idx, input logic [23:0] exp);
      rd_bank  = 1'(bank);
      rd_index = 2'(idx);
      tick();
      check(tag, {8'h00, rd_rgb}, {8'h00, exp});
   endtask

   task automatic vblank_no_commit(input string tag);
      vblank = 1'b1;
      tick();
      check(tag, {31'd0, commit_pulse}, 32'd0);
      tick();
      check(tag, {31'd0, commit_pulse}, 32'd0);
      vblank = 1'b0;
      tick();
   endtask

   initial begin
      reset          = 1'b1;
      ioctl_download = 1'b0;
      ioctl_index    = 8'd0;
      ioctl_wr       = 1'b0;
      ioctl_data     = 8'd0;
      load_bank      = 1'b0;
      vblank         = 1'b0;
      rd_bank        = 1'b0;
      rd_index       = 2'd0;
      tick();
      tick();
      check("rst_rgb",     {8'h00, rd_rgb}, 32'h0);
      check("rst_busy",    {31'd0, busy}, 32'd0);
      check("rst_pending", {31'd0, pending}, 32'd0);
      check("rst_errs",    {30'd0, err_short, err_long}, 32'd0);
      check("rst_commit",  {31'd0, commit_pulse}, 32'd0);
      reset = 1'b0;
      tick();

      // 1: default palette contents
      read("def_b0_i1", 0, 1, 24'h320000);
      read("def_b0_i2", 0, 2, 24'h00ffff);
      read("def_b1_i0", 1, 0, 24'h000032);

      // 2: full download to bank 1 and commit
      start_dl(1, 3);
      check("t2_busy", {31'd0, busy}, 32'd1);
      send_bytes(16, 8'h00, 8'h11);
      end_dl();
      check("t2_pending", {31'd0, pending}, 32'd1);
      check("t2_errs", {30'd0, err_short, err_long}, 32'd0);
      read("t2_pre_commit", 1, 0, 24'h000032);
      vblank = 1'b1;
      tick();
      check("t2_commit", {31'd0, commit_pulse}, 32'd1);
      check("t2_old_read", {8'h00, rd_rgb}, 32'h000032);
      check("t2_pend_clr", {31'd0, pending}, 32'd0);
      tick();
      check("t2_commit_once", {31'd0, commit_pulse}, 32'd0);
      check("t2_new_read", {8'h00, rd_rgb}, 32'h112233);
      vblank = 1'b0;
      tick();
      vblank_no_commit("t2_idle_vblank");
      read("t2_b1_i3", 1, 3, 24'hddeeff);
      read("t2_b0_i1", 0, 1, 24'h320000);

      // 3: short download
      start_dl(0, 3);
      send_bytes(10, 8'ha0, 1);
      end_dl();
      check("t3_short", {31'd0, err_short}, 32'd1);
      check("t3_long", {31'd0, err_long}, 32'd0);
      check("t3_pending", {31'd0, pending}, 32'd0);
      vblank_no_commit("t3_vblank");
      read("t3_b0_i1", 0, 1, 24'h320000);

      // 4: long download, then a good one clears the flag
      start_dl(0, 3);
      check("t4_short_clr", {31'd0, err_short}, 32'd0);
      send_bytes(20, 8'h20, 1);
      end_dl();
      check("t4_long", {31'd0, err_long}, 32'd1);
      check("t4_short", {31'd0, err_short}, 32'd0);
      check("t4_pending", {31'd0, pending}, 32'd0);
      vblank_no_commit("t4_vblank");
      read("t4_b0_i0", 0, 0, 24'h000032);
      start_dl(0, 3);
      check("t4_long_clr", {31'd0, err_long}, 32'd0);
      send_bytes(16, 8'h80, 1);
      end_dl();
      check("t4_pending2", {31'd0, pending}, 32'd1);
      check("t4_long_after", {31'd0, err_long}, 32'd0);
      vblank = 1'b1;
      tick();
      check("t4_commit", {31'd0, commit_pulse}, 32'd1);
      vblank = 1'b0;
      tick();
      read("t4_b0_i1", 0, 1, 24'h858687);
      read("t4_b1_i0", 1, 0, 24'h112233);

      // 5: vblank already high when the download completes
      vblank = 1'b1;
      tick();
      start_dl(1, 3);
      send_bytes(16, 8'h40, 1);
      end_dl();
      check("t5_pending", {31'd0, pending}, 32'd1);
      tick();
      check("t5_no_commit_hi", {31'd0, commit_pulse}, 32'd0);
      vblank = 1'b0;
      tick();
      check("t5_no_commit_lo", {31'd0, commit_pulse}, 32'd0);
      check("t5_still_pend", {31'd0, pending}, 32'd1);
      vblank = 1'b1;
      tick();
      check("t5_commit", {31'd0, commit_pulse}, 32'd1);
      vblank = 1'b0;
      tick();
      read("t5_b1_i2", 1, 2, 24'h494a4b);

      // 5b: restart during PEND, with vblank rising on the same cycle
      start_dl(1, 3);
      send_bytes(16, 8'h50, 1);
      end_dl();
      check("t5b_pending", {31'd0, pending}, 32'd1);
      vblank         = 1'b1;
      ioctl_download = 1'b1;
      tick();
      check("t5b_no_commit", {31'd0, commit_pulse}, 32'd0);
      check("t5b_pend_clr", {31'd0, pending}, 32'd0);
      check("t5b_busy", {31'd0, busy}, 32'd1);
      vblank = 1'b0;
      send_bytes(16, 8'h60, 1);
      end_dl();
      vblank = 1'b1;
      tick();
      check("t5b_commit", {31'd0, commit_pulse}, 32'd1);
      vblank = 1'b0;
      tick();
      read("t5b_b1_i0", 1, 0, 24'h616263);
      read("t5b_b1_i3", 1, 3, 24'h6d6e6f);

      // 6: reset mid-download restores defaults
      start_dl(0, 3);
      send_bytes(7, 8'h90, 1);
      reset = 1'b1;
      tick();
      check("t6_busy", {31'd0, busy}, 32'd0);
      check("t6_rgb", {8'h00, rd_rgb}, 32'h0);
      reset          = 1'b0;
      ioctl_download = 1'b0;
      tick();
      read("t6_b0_i1", 0, 1, 24'h320000);
      read("t6_b1_i0", 1, 0, 24'h000032);

      // 6b: other ioctl index is ignored
      start_dl(1, 1);
      check("t6b_busy", {31'd0, busy}, 32'd0);
      send_bytes(16, 8'h70, 1);
      end_dl();
      check("t6b_pending", {31'd0, pending}, 32'd0);
      check("t6b_errs", {30'd0, err_short, err_long}, 32'd0);
      vblank_no_commit("t6b_vblank");
      read("t6b_b1_i0", 1, 0, 24'h000032);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
